mem_readout_core: RTL and testbench
===================================

// Module: mem_readout_core
// PURPOSE
//  Priority-encoded readout of 12 item memories (45-bit entries) into one serial stream.
//  At each new event, latches per-memory item counts. Then, one entry per clock, issues read
//  addresses to the lowest-numbered memory that still has unread items.
//  Returned data is muxed onto mem_dat_stream with a valid strobe; none flags that all memories are drained.
// PARAMETERS
//  NMEM        12    number of source memories (ports 00..11 fixed)
//  DW          45    memory entry width
//  RD_LAT      2     cycles from addrNN output to matching mem_datNN (1 external addr reg + 1 RAM reg)
//  MAX_CYC     7'd100 last clk_cnt value at which a read may be issued within a BX window
// PORTS
//  clk          in   1    main clock, all logic on posedge
//  reset        in   1    asynchronous, active-low reset
//  new_event    in   1    1-cycle pulse: start readout of a new event
//  BX           in   3    event BX number (registered into bx_q on new_event, status only)
//  clk_cnt      in   7    cycles elapsed in current BX window
//  BX_pipe      in   3    pipeline BX; bit0 selects memory page
//  items00..11  in   6    item count held in each memory
//  mem_dat00..11 in  45   read data from each memory
//  addr00..11   out  6    read address per memory = {page, index[4:0]}
//  mem_dat_stream out 45  selected memory data
//  valid        out  1    mem_dat_stream holds a real item this cycle
//  none         out  1    no unread items remain in any memory
// BEHAVIOUR
//  - Reset values (reset low, async): cnt[i]=0, idx[i]=0, addrNN=0, pipeline valid bits=0,
//    mem_dat_stream=0, valid=0, none=1.
//  - On posedge with new_event=1:
//    - cnt[i] <= min(itemsNN, 32), since 5-bit index gives 32 entries max.
//    - idx[i] <= 0; no read is issued that cycle.
//  - Issue cycle, when new_event=0, some cnt[i]!=0 and clk_cnt<=MAX_CYC:
//    - Fixed priority picks the lowest i with cnt[i]!=0.
//    - addr_i <= {BX_pipe[0], idx[i]}; idx[i]++; cnt[i]--.
//    - All other addrNN hold their last value.
//  - sel (4b) and issue flag are delayed RD_LAT cycles in a shift pipeline.
//    - At the tap: mem_dat_stream <= mem_dat[sel_d]; valid <= issue_d.
//    - When issue_d=0: mem_dat_stream holds its value and valid=0.
//  - Output latency: first item's valid is asserted RD_LAT+1 cycles after the issue edge (register at output).
//  - none is combinational: 1 iff all cnt[i]==0. It is 0 from the cycle after new_event with any nonzero count.
//  - A new_event arriving mid-readout:
//    - Reloads counts and abandons remaining items.
//    - Entries already in the pipeline still emerge with valid=1.
//  - clk_cnt>MAX_CYC stalls issuing; counts are preserved and issuing resumes if clk_cnt wraps below MAX_CYC.
//  - itemsNN=0: memory is skipped entirely. itemsNN>=32: exactly 32 entries are read (idx 0..31, no wrap).
//  - Throughput: exactly one item per cycle while issuing. Total cycles = sum of clamped counts.
// TESTING
//  1. Assert reset low mid-run -> all addr=0, valid=0, none=1 immediately. Release, no new_event -> stays idle.
//  2. items={0,1,24,2,0,0,4,0,8,1,24,0}, new_event, clk_cnt from 0:
//     - Stream order: m01 idx0; m02 idx0..23; m03 idx0..1; m06 0..3; m08 0..7; m09 0; m10 0..23.
//     - 64 consecutive valid cycles, then none=1, valid=0.
//  3. Entry word = {memid, idx}. Check each streamed word equals the data at the issued address
//     (RD_LAT alignment), with valid first high 3 cycles after the first issue edge.
//  4. All items=0 -> none stays 1, valid never asserts, addresses unchanged.
//  5. items02=63 -> exactly 32 reads of m02 (idx 0..31), then none=1.
//  6. new_event every 51 cycles with items02=24 and others 0:
//     - Second event restarts m02 at idx0.
//     - BX_pipe[0]=1 sets addr02 bit5.
//     - Second event with clk_cnt forced to 101 -> no issue until clk_cnt<=100.

Source files
------------

// File: rtl/mem_readout_core.sv
// Priority-encoded readout of twelve item memories into one serial 45-bit stream.
// Counts are latched per event; one entry per clock is read from the lowest memory with work left.
module mem_readout_core #(
  parameter int          DW      = 45,
  parameter int          RD_LAT  = 2,
  parameter logic [6:0]  MAX_CYC = 7'd100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          new_event,
  input  logic [2:0]    BX,
  input  logic [6:0]    clk_cnt,
  input  logic [2:0]    BX_pipe,
  input  logic [5:0]    items00,
  input  logic [5:0]    items01,
  input  logic [5:0]    items02,
  input  logic [5:0]    items03,
  input  logic [5:0]    items04,
  input  logic [5:0]    items05,
  input  logic [5:0]    items06,
  input  logic [5:0]    items07,
  input  logic [5:0]    items08,
  input  logic [5:0]    items09,
  input  logic [5:0]    items10,
  input  logic [5:0]    items11,
  input  logic [DW-1:0] mem_dat00,
  input  logic [DW-1:0] mem_dat01,
  input  logic [DW-1:0] mem_dat02,
  input  logic [DW-1:0] mem_dat03,
  input  logic [DW-1:0] mem_dat04,
  input  logic [DW-1:0] mem_dat05,
  input  logic [DW-1:0] mem_dat06,
  input  logic [DW-1:0] mem_dat07,
  input  logic [DW-1:0] mem_dat08,
  input  logic [DW-1:0] mem_dat09,
  input  logic [DW-1:0] mem_dat10,
  input  logic [DW-1:0] mem_dat11,
  output logic [5:0]    addr00,
  output logic [5:0]    addr01,
  output logic [5:0]    addr02,
  output logic [5:0]    addr03,
  output logic [5:0]    addr04,
  output logic [5:0]    addr05,
  output logic [5:0]    addr06,
  output logic [5:0]    addr07,
  output logic [5:0]    addr08,
  output logic [5:0]    addr09,
  output logic [5:0]    addr10,
  output logic [5:0]    addr11,
  output logic [DW-1:0] mem_dat_stream,
  output logic          valid,
  output logic          none
);

  localparam int NMEM = 12;

  logic [5:0]    items_s   [NMEM];
  logic [DW-1:0] mem_dat_s [NMEM];
  logic [5:0]    cnt_r     [NMEM];
  logic [4:0]    idx_r     [NMEM];
  logic [5:0]    addr_r    [NMEM];
  logic [3:0]    sel_pipe_r [RD_LAT+1];
  logic          iss_pipe_r [RD_LAT+1];
  logic [2:0]    bx_q_r;
  logic [3:0]    sel_s;
  logic          any_s;
  logic          issue_s;

  function automatic logic [5:0] clamp_items(input logic [5:0] n);
    return (n > 6'd32) ? 6'd32 : n;
  endfunction

  assign items_s[0]  = items00;
  assign items_s[1]  = items01;
  assign items_s[2]  = items02;
  assign items_s[3]  = items03;
  assign items_s[4]  = items04;
  assign items_s[5]  = items05;
  assign items_s[6]  = items06;
  assign items_s[7]  = items07;
  assign items_s[8]  = items08;
  assign items_s[9]  = items09;
  assign items_s[10] = items10;
  assign items_s[11] = items11;

  assign mem_dat_s[0]  = mem_dat00;
  assign mem_dat_s[1]  = mem_dat01;
  assign mem_dat_s[2]  = mem_dat02;
  assign mem_dat_s[3]  = mem_dat03;
  assign mem_dat_s[4]  = mem_dat04;
  assign mem_dat_s[5]  = mem_dat05;
  assign mem_dat_s[6]  = mem_dat06;
  assign mem_dat_s[7]  = mem_dat07;
  assign mem_dat_s[8]  = mem_dat08;
  assign mem_dat_s[9]  = mem_dat09;
  assign mem_dat_s[10] = mem_dat10;
  assign mem_dat_s[11] = mem_dat11;

  assign addr00 = addr_r[0];
  assign addr01 = addr_r[1];
  assign addr02 = addr_r[2];
  assign addr03 = addr_r[3];
  assign addr04 = addr_r[4];
  assign addr05 = addr_r[5];
  assign addr06 = addr_r[6];
  assign addr07 = addr_r[7];
  assign addr08 = addr_r[8];
  assign addr09 = addr_r[9];
  assign addr10 = addr_r[10];
  assign addr11 = addr_r[11];

  // Fixed-priority pick of the lowest memory that still has unread items.
  always_comb begin
    sel_s = 4'd0;
    any_s = 1'b0;
    for (int i = NMEM - 1; i >= 0; i--) begin
      if (cnt_r[i] != 6'd0) begin
        sel_s = 4'(i);
        any_s = 1'b1;
      end else begin
        any_s = any_s;
      end
    end
  end

  // The load cycle of a new event never issues; past MAX_CYC issuing stalls with counts kept.
  assign issue_s = ~new_event & any_s & (clk_cnt <= MAX_CYC);
  assign none    = ~any_s;

  // Per-memory remaining count, read index and address register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NMEM; i++) begin
        cnt_r[i]  <= 6'd0;
        idx_r[i]  <= 5'd0;
        addr_r[i] <= 6'd0;
      end
      bx_q_r <= 3'd0;
    end else if (new_event) begin
      for (int i = 0; i < NMEM; i++) begin
        cnt_r[i] <= clamp_items(items_s[i]);
        idx_r[i] <= 5'd0;
      end
      bx_q_r <= BX;
    end else if (issue_s) begin
      cnt_r[sel_s]  <= cnt_r[sel_s] - 6'd1;
      idx_r[sel_s]  <= idx_r[sel_s] + 5'd1;
      addr_r[sel_s] <= {BX_pipe[0], idx_r[sel_s]};
    end else begin
      bx_q_r <= bx_q_r;
    end
  end

  // Stage 0 lines up with the address register; the tap meets data RD_LAT cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        sel_pipe_r[k] <= 4'd0;
        iss_pipe_r[k] <= 1'b0;
      end
    end else begin
      sel_pipe_r[0] <= sel_s;
      iss_pipe_r[0] <= issue_s;
      for (int k = 1; k <= RD_LAT; k++) begin
        sel_pipe_r[k] <= sel_pipe_r[k-1];
        iss_pipe_r[k] <= iss_pipe_r[k-1];
      end
    end
  end

  // Output register: capture the selected memory's data when a real read arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_dat_stream <= {DW{1'b0}};
      valid          <= 1'b0;
    end else if (iss_pipe_r[RD_LAT]) begin
      mem_dat_stream <= mem_dat_s[sel_pipe_r[RD_LAT]];
      valid          <= 1'b1;
    end else begin
      valid          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_readout_core.sv
// Directed bench for mem_readout_core: a two-register memory model returns {memid, addr}
// and each streamed word, valid and none are compared against hand-derived expectations.
module tb_mem_readout_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_event;
  logic [2:0]  BX;
  logic [6:0]  clk_cnt;
  logic [2:0]  BX_pipe;
  logic [5:0]  items   [12];
  logic [44:0] mem_dat [12];
  logic [5:0]  addr    [12];
  logic [5:0]  addr_q  [12];
  logic [44:0] stream;
  logic        valid;
  logic        none;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [44:0] exp_q [$];

  always #5 clk = ~clk;

  mem_readout_core dut (
    .clk(clk), .reset(reset), .new_event(new_event), .BX(BX), .clk_cnt(clk_cnt), .BX_pipe(BX_pipe),
    .items00(items[0]), .items01(items[1]), .items02(items[2]), .items03(items[3]),
    .items04(items[4]), .items05(items[5]), .items06(items[6]), .items07(items[7]),
    .items08(items[8]), .items09(items[9]), .items10(items[10]), .items11(items[11]),
    .mem_dat00(mem_dat[0]), .mem_dat01(mem_dat[1]), .mem_dat02(mem_dat[2]), .mem_dat03(mem_dat[3]),
    .mem_dat04(mem_dat[4]), .mem_dat05(mem_dat[5]), .mem_dat06(mem_dat[6]), .mem_dat07(mem_dat[7]),
    .mem_dat08(mem_dat[8]), .mem_dat09(mem_dat[9]), .mem_dat10(mem_dat[10]), .mem_dat11(mem_dat[11]),
    .addr00(addr[0]), .addr01(addr[1]), .addr02(addr[2]), .addr03(addr[3]),
    .addr04(addr[4]), .addr05(addr[5]), .addr06(addr[6]), .addr07(addr[7]),
    .addr08(addr[8]), .addr09(addr[9]), .addr10(addr[10]), .addr11(addr[11]),
    .mem_dat_stream(stream), .valid(valid), .none(none)
  );

  // External address register followed by a registered RAM: two cycles from addr to data.
  always @(posedge clk) begin
    for (int i = 0; i < 12; i++) begin
      addr_q[i]  <= addr[i];
      mem_dat[i] <= {35'd0, 4'(i), addr_q[i]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input logic page);
    int c;
    exp_q.delete();
    for (int m = 0; m < 12; m++) begin
      c = (items[m] > 6'd32) ? 32 : int'(items[m]);
      for (int j = 0; j < c; j++) exp_q.push_back({35'd0, 4'(m), page, 5'(j)});
    end
  endtask

  task automatic set_items(input logic [5:0] v [12]);
    for (int i = 0; i < 12; i++) items[i] = v[i];
  endtask

  // Called at a negedge; returns at the negedge right after the load edge.
  task automatic fire_event(input logic [2:0] bxp, input logic [6:0] cc);
    BX_pipe   = bxp;
    clk_cnt   = cc;
    BX        = BX + 3'd1;
    new_event = 1'b1;
    @(negedge clk);
    new_event = 1'b0;
  endtask

  // n counts edges after the load edge; reads issue at edges first..first+total-1.
  task automatic run_check(input string tag, input int first, input int total, input int stall_n);
    int   k = 0;
    logic exp_v;
    logic exp_none;
    for (int n = 1; n <= first + total + 5; n++) begin
      @(negedge clk);
      exp_v    = (total > 0) && (n >= first + 3) && (n < first + 3 + total);
      exp_none = (total == 0) || (n >= first + total - 1);
      chk({tag, "_valid"}, {63'd0, valid}, {63'd0, exp_v});
      chk({tag, "_none"},  {63'd0, none},  {63'd0, exp_none});
      if (exp_v) begin
        chk({tag, "_data"}, {19'd0, stream}, {19'd0, exp_q[k]});
        k++;
      end
      if (n == stall_n) clk_cnt = 7'd100;
    end
  endtask

  logic [5:0] tab2 [12] = '{6'd0, 6'd1, 6'd24, 6'd2, 6'd0, 6'd0, 6'd4, 6'd0, 6'd8, 6'd1, 6'd24, 6'd0};
  logic [5:0] tab0 [12] = '{default: 6'd0};
  logic [5:0] tab5 [12] = '{6'd0, 6'd0, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
  logic [5:0] tab6 [12] = '{6'd0, 6'd0, 6'd24, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

  initial begin
    reset = 1'b0; new_event = 1'b0; BX = 3'd0; clk_cnt = 7'd0; BX_pipe = 3'd0;
    set_items(tab0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) chk("rst_addr", {58'd0, addr[i]}, 64'd0);
    chk("rst_valid",  {63'd0, valid}, 64'd0);
    chk("rst_none",   {63'd0, none},  64'd1);
    chk("rst_stream", {19'd0, stream}, 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid", {63'd0, valid}, 64'd0);
    chk("idle_none",  {63'd0, none},  64'd1);

    // Mixed counts: 64 items in memory order
    set_items(tab2);
    build_exp(1'b0);
    fire_event(3'd0, 7'd0);
    run_check("t2", 1, 64, 0);
    chk("t2_addr01", {58'd0, addr[1]},  64'd0);
    chk("t2_addr02", {58'd0, addr[2]},  64'd23);
    chk("t2_addr03", {58'd0, addr[3]},  64'd1);
    chk("t2_addr06", {58'd0, addr[6]},  64'd3);
    chk("t2_addr08", {58'd0, addr[8]},  64'd7);
    chk("t2_addr10", {58'd0, addr[10]}, 64'd23);

    // Empty event: nothing issued, addresses untouched
    set_items(tab0);
    build_exp(1'b0);
    fire_event(3'd0, 7'd0);
    run_check("t4", 1, 0, 0);
    chk("t4_addr02", {58'd0, addr[2]},  64'd23);
    chk("t4_addr10", {58'd0, addr[10]}, 64'd23);

    // Oversized count clamps to 32 reads
    set_items(tab5);
    build_exp(1'b0);
    fire_event(3'd0, 7'd0);
    run_check("t5", 1, 32, 0);
    chk("t5_addr02", {58'd0, addr[2]}, 64'd31);

    // Repeated events, second on page 1 and stalled past MAX_CYC
    set_items(tab6);
    build_exp(1'b0);
    fire_event(3'd0, 7'd0);
    run_check("t6a", 1, 24, 0);
    repeat (20) @(negedge clk);
    build_exp(1'b1);
    fire_event(3'b001, 7'd101);
    run_check("t6b", 6, 24, 5);
    chk("t6_addr02", {58'd0, addr[2]}, 64'h37);

    // Asynchronous reset in the middle of a readout
    build_exp(1'b0);
    fire_event(3'd0, 7'd0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) chk("mid_rst_addr", {58'd0, addr[i]}, 64'd0);
    chk("mid_rst_valid", {63'd0, valid}, 64'd0);
    chk("mid_rst_none",  {63'd0, none},  64'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", {63'd0, valid}, 64'd0);
    chk("post_rst_none",  {63'd0, none},  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
